buffer5_ctrl: RTL and testbench

- Sequencer for the 640-wide, 5-line tap buffer that feeds the 5x5 edge-detect window.
- Accepts a raster pixel stream with valid/ready and start-of-frame, and drives the buffer's clock enable and shift-in data.
- Tracks which source pixel sits at the window centre and flags when the full 5x5 neighbourhood is in-frame.
- Flushes the buffer with zero pixels at frame end so every centre pixel is presented downstream.

---
 rtl/buffer5_pkg.sv | 23 ++
 rtl/buffer5_ctrl_if.sv | 34 +++
 rtl/buffer5_ctrl_raster_counter.sv | 42 ++++
 rtl/buffer5_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_buffer5_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/buffer5_pkg.sv
// Shared definitions for the 5-line tap buffer sequencer: state encoding,
// default frame geometry, priming depth and coordinate widths.
package buffer5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Shifts needed before the window centre tap (line3[line_w-3]) holds pixel 0.
    function automatic int prime_of(input int line_w);
        return 3 * line_w - 2;
    endfunction

    localparam int LINE_W_DEF = 640;
    localparam int LINES_DEF  = 480;
    localparam int PRIME_DEF  = prime_of(LINE_W_DEF);

    localparam int CX_W = 10;
    localparam int CY_W = 9;

endpackage

// File: rtl/buffer5_ctrl_if.sv
// Pixel stream, buffer drive and window status bundle for buffer5_ctrl.
// master = upstream/downstream environment, slave = the controller.
interface buffer5_ctrl_if #(
    parameter int P_BIT_WIDTH = 24
);
    import buffer5_pkg::*;

    logic [P_BIT_WIDTH-1:0] iPixel;
    logic                   iValid;
    logic                   iSof;
    logic                   iHold;
    logic                   oReady;
    logic                   oClken;
    logic [P_BIT_WIDTH-1:0] oShiftin;
    logic                   oWinValid;
    logic [CX_W-1:0]        oCx;
    logic [CY_W-1:0]        oCy;
    logic                   oBorder;
    logic                   oFrameDone;
    logic                   oBusy;

    modport master (
        output iPixel, iValid, iSof, iHold,
        input  oReady, oClken, oShiftin, oWinValid, oCx, oCy, oBorder,
               oFrameDone, oBusy
    );

    modport slave (
        input  iPixel, iValid, iSof, iHold,
        output oReady, oClken, oShiftin, oWinValid, oCx, oCy, oBorder,
               oFrameDone, oBusy
    );

endinterface

// File: rtl/buffer5_ctrl_raster_counter.sv
// raster_counter: x/y position counter for a P_W x P_H raster.
// x wraps at P_W-1 and carries into y; y wraps at P_H-1. Load beats enable.
module raster_counter
    import buffer5_pkg::*;
#(
    parameter int P_W  = LINE_W_DEF,
    parameter int P_H  = LINES_DEF,
    parameter int P_XW = CX_W,
    parameter int P_YW = CY_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic [P_XW-1:0] load_x,
    input  logic [P_YW-1:0] load_y,
    output logic [P_XW-1:0] x,
    output logic [P_YW-1:0] y
);

    localparam logic [P_XW-1:0] X_MAX = P_XW'(P_W - 1);
    localparam logic [P_YW-1:0] Y_MAX = P_YW'(P_H - 1);

    // Position register: synchronous load, otherwise raster-order advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= load_x;
            y <= load_y;
        end else if (en) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/buffer5_ctrl.sv
// buffer5_ctrl: sequencer for the 5-line tap buffer feeding the 5x5 window.
// Streams pixels into the buffer, tracks the source pixel at the window
// centre and flushes with zeros at frame end.
// Optional build macro BUFFER5_CTRL_BORDER_PASS_EN: report every centre as a
// valid window and flag edge centres on oBorder (default: interior only).
//
//   state | meaning
//   IDLE  | waiting for a start-of-frame pixel; non-SOF pixels are dropped
//   RUN   | shifting accepted pixels into the buffer
//   FLUSH | shifting P_PRIME zero pixels to push out the last centres
module buffer5_ctrl
    import buffer5_pkg::*;
#(
    parameter int P_BIT_WIDTH = 24,
    parameter int P_LINE_W    = LINE_W_DEF,
    parameter int P_LINES     = LINES_DEF,
    parameter int P_PRIME     = prime_of(P_LINE_W)
) (
    input  logic          clk,
    input  logic          reset,
    buffer5_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    localparam int              PW       = $clog2(P_PRIME + 1);
    localparam logic [PW-1:0]   PRIME_LD = PW'(P_PRIME);
    localparam logic [PW-1:0]   PRIME_GO = PW'(P_PRIME - 1);
    localparam logic [PW-1:0]   ONE      = PW'(1);
    localparam logic [CX_W-1:0] X_LAST   = CX_W'(P_LINE_W - 1);
    localparam logic [CY_W-1:0] Y_LAST   = CY_W'(P_LINES - 1);
    localparam logic [CX_W-1:0] X_IN_LO  = CX_W'(2);
    localparam logic [CX_W-1:0] X_IN_HI  = CX_W'(P_LINE_W - 3);
    localparam logic [CY_W-1:0] Y_IN_LO  = CY_W'(2);
    localparam logic [CY_W-1:0] Y_IN_HI  = CY_W'(P_LINES - 3);

    localparam logic [P_BIT_WIDTH-1:0] PIX_ZERO = '0;

    logic [1:0]      state_q;
    logic [PW-1:0]   prime_rem_q;
    logic [PW-1:0]   flush_rem_q;
    logic            loaded_q;
    logic            frame_done_q;

    logic [CX_W-1:0] in_x;
    logic [CY_W-1:0] in_y;
    logic [CX_W-1:0] cx;
    logic [CY_W-1:0] cy;

    logic clken;
    logic ready;
    logic start;
    logic in_en;
    logic in_last;
    logic prime_hit;
    logic c_last;
    logic c_load;
    logic c_en;
    logic interior;

    // Handshake and buffer clock enable per state. Hold in IDLE also
    // withdraws ready so a start-of-frame pixel is never swallowed unshifted.
    always_comb begin
        ready = 1'b0;
        clken = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = !bus.iHold;
                clken = bus.iValid & bus.iSof & !bus.iHold;
            end
            ST_RUN: begin
                ready = !bus.iHold;
                clken = bus.iValid & !bus.iHold;
            end
            ST_FLUSH: begin
                clken = !bus.iHold;
            end
            default: ;
        endcase
    end

    assign start     = clken & bus.iSof & (state_q != ST_FLUSH);
    assign in_en     = clken & (state_q == ST_RUN) & !bus.iSof;
    assign in_last   = (in_x == X_LAST) && (in_y == Y_LAST);
    assign prime_hit = clken & !start & (prime_rem_q == ONE);
    assign c_last    = (cx == X_LAST) && (cy == Y_LAST);
    // The pulse after the last centre retires the window rather than wrapping.
    assign c_load    = start | prime_hit | (clken & loaded_q & c_last);
    assign c_en      = clken & loaded_q & !c_last & !start;
    assign interior  = (cx >= X_IN_LO) && (cx <= X_IN_HI) &&
                       (cy >= Y_IN_LO) && (cy <= Y_IN_HI);

    // Position of the next pixel to be accepted; SOF pixel is pixel 0.
    raster_counter #(
        .P_W  (P_LINE_W),
        .P_H  (P_LINES),
        .P_XW (CX_W),
        .P_YW (CY_W)
    ) u_in_pos (
        .clk    (clk),
        .reset  (reset),
        .en     (in_en),
        .load   (start),
        .load_x (CX_W'(1)),
        .load_y ('0),
        .x      (in_x),
        .y      (in_y)
    );

    // Source coordinate currently at the window centre.
    raster_counter #(
        .P_W  (P_LINE_W),
        .P_H  (P_LINES),
        .P_XW (CX_W),
        .P_YW (CY_W)
    ) u_centre_pos (
        .clk    (clk),
        .reset  (reset),
        .en     (c_en),
        .load   (c_load),
        .load_x ('0),
        .load_y ('0),
        .x      (cx),
        .y      (cy)
    );

    // Frame sequencing, flush down-counter and end-of-frame pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            flush_rem_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (in_en && in_last) begin
                        state_q     <= ST_FLUSH;
                        flush_rem_q <= PRIME_LD;
                    end
                end
                ST_FLUSH: begin
                    if (clken) begin
                        flush_rem_q <= flush_rem_q - 1'b1;
                        if (flush_rem_q == ONE) begin
                            state_q      <= ST_IDLE;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Priming down-counter; the SOF pulse itself is the first priming shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_rem_q <= '0;
        end else if (start) begin
            prime_rem_q <= PRIME_GO;
        end else if (clken && (prime_rem_q != '0)) begin
            prime_rem_q <= prime_rem_q - 1'b1;
        end
    end

    // Centre-loaded flag: set when priming completes, cleared on restart or
    // once the last centre has been shifted past.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loaded_q <= 1'b0;
        end else if (start) begin
            loaded_q <= 1'b0;
        end else if (prime_hit) begin
            loaded_q <= 1'b1;
        end else if (clken && loaded_q && c_last) begin
            loaded_q <= 1'b0;
        end
    end

    assign bus.oReady     = ready;
    assign bus.oClken     = clken;
    assign bus.oShiftin   = (state_q == ST_FLUSH) ? PIX_ZERO : bus.iPixel;
    assign bus.oCx        = cx;
    assign bus.oCy        = cy;
    assign bus.oFrameDone = frame_done_q;
    assign bus.oBusy      = (state_q != ST_IDLE);

`ifdef BUFFER5_CTRL_BORDER_PASS_EN
    assign bus.oWinValid  = loaded_q;
    assign bus.oBorder    = loaded_q & !interior;
`else
    assign bus.oWinValid  = loaded_q & interior;
    assign bus.oBorder    = 1'b0;
`endif

endmodule

// File: tb/tb_buffer5_ctrl.sv
// Directed bench for buffer5_ctrl on a reduced 8x6 raster (prime depth 22).
module tb_buffer5_ctrl;
    import buffer5_pkg::*;

    localparam int BW    = 8;
    localparam int W     = 8;
    localparam int H     = 6;
    localparam int PR    = 3 * W - 2;
    localparam int FRAME = W * H;

`ifdef BUFFER5_CTRL_BORDER_PASS_EN
    localparam int EXP_WIN  = FRAME;
    localparam int EXP_BORD = FRAME - (W - 4) * (H - 4);
    localparam int FIRST_X  = 0;
    localparam int FIRST_Y  = 0;
    localparam int LAST_X   = W - 1;
    localparam int LAST_Y   = H - 1;
    localparam int EXP_PRE  = 23;
`else
    localparam int EXP_WIN  = (W - 4) * (H - 4);
    localparam int EXP_BORD = 0;
    localparam int FIRST_X  = 2;
    localparam int FIRST_Y  = 2;
    localparam int LAST_X   = W - 3;
    localparam int LAST_Y   = H - 3;
    localparam int EXP_PRE  = 4;
`endif

    logic clk;
    logic reset;

    buffer5_ctrl_if #(.P_BIT_WIDTH(BW)) bus ();

    buffer5_ctrl #(
        .P_BIT_WIDTH (BW),
        .P_LINE_W    (W),
        .P_LINES     (H)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int idx = 0;
    int restart_at = 0;
    int clk_cnt = 0;
    int win_cnt = 0;
    int bord_cnt = 0;
    int fd_cnt = 0;
    int fd_cyc = 0;
    int last_clk_cyc = 0;
    int pre_win = 0;
    int first_x = 0;
    int first_y = 0;
    int last_x = 0;
    int last_y = 0;
    bit feed_en = 0;
    bit hold_en = 0;
    bit gap_en = 0;
    bit nosof_en = 0;
    bit prev_clken = 0;
    bit prev_hold_busy = 0;
    bit after_restart = 0;
    logic [CX_W-1:0] snap_cx;
    logic [CY_W-1:0] snap_cy;
    logic snap_wv;
    logic snap_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (restart_at > 0 && idx == restart_at) begin
            idx = 0;
            restart_at = 0;
        end
        bus.iHold = hold_en && (cyc % 5 == 3);
        if (nosof_en) begin
            bus.iValid = 1'b1;
            bus.iSof   = 1'b0;
            bus.iPixel = 8'h55;
        end else if (feed_en && idx < FRAME) begin
            bus.iValid = !(gap_en && (cyc % 7 == 2));
            bus.iSof   = (idx == 0);
            bus.iPixel = BW'(idx + 1);
        end else begin
            bus.iValid = 1'b0;
            bus.iSof   = 1'b0;
            bus.iPixel = 8'hA5;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (after_restart) begin
            chk("restart_winvalid", bus.oWinValid, 0);
            chk("restart_cx", bus.oCx, 0);
            chk("restart_cy", bus.oCy, 0);
            after_restart = 1'b0;
        end
        if (prev_hold_busy) begin
            chk("hold_cx", bus.oCx, snap_cx);
            chk("hold_cy", bus.oCy, snap_cy);
            chk("hold_winvalid", bus.oWinValid, snap_wv);
            chk("hold_busy", bus.oBusy, snap_busy);
        end
        if (bus.iHold && bus.oBusy) begin
            chk("hold_clken", bus.oClken, 0);
            chk("hold_ready", bus.oReady, 0);
        end
        if (prev_clken && bus.oWinValid) begin
            win_cnt++;
            if (win_cnt == 1) begin
                first_x = int'(bus.oCx);
                first_y = int'(bus.oCy);
            end
            last_x = int'(bus.oCx);
            last_y = int'(bus.oCy);
            chk("win_pulse", clk_cnt, PR + int'(bus.oCy) * W + int'(bus.oCx));
        end
        if (prev_clken && bus.oBorder) bord_cnt++;
        if (bus.oFrameDone) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (bus.oClken) begin
            if (bus.iSof && bus.iValid) begin
                if (bus.oBusy) begin
                    pre_win = win_cnt;
                    after_restart = 1'b1;
                end
                clk_cnt = 0;
                win_cnt = 0;
                bord_cnt = 0;
            end
            clk_cnt++;
            last_clk_cyc = cyc;
            if (bus.iValid) begin
                chk("shiftin_run", bus.oShiftin, bus.iPixel);
                idx++;
            end else begin
                chk("flush_zero", bus.oShiftin, 0);
            end
        end
        prev_clken     = bus.oClken;
        prev_hold_busy = bus.iHold && bus.oBusy;
        snap_cx        = bus.oCx;
        snap_cy        = bus.oCy;
        snap_wv        = bus.oWinValid;
        snap_busy      = bus.oBusy;
        cyc++;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_frame(input string tag);
        fd_cnt = 0;
        win_cnt = 0;
        bord_cnt = 0;
        prev_clken = 0;
        prev_hold_busy = 0;
        idx = 0;
        feed_en = 1;
        drive();
        for (int n = 0; n < 400 && fd_cnt == 0; n++) step();
        repeat (3) step();
        chk({tag, "_frame_done_cnt"}, fd_cnt, 1);
        chk({tag, "_clken_total"}, clk_cnt, FRAME + PR);
        chk({tag, "_done_delay"}, fd_cyc - last_clk_cyc, 1);
        chk({tag, "_win_cnt"}, win_cnt, EXP_WIN);
        chk({tag, "_border_cnt"}, bord_cnt, EXP_BORD);
        chk({tag, "_first_x"}, first_x, FIRST_X);
        chk({tag, "_first_y"}, first_y, FIRST_Y);
        chk({tag, "_last_x"}, last_x, LAST_X);
        chk({tag, "_last_y"}, last_y, LAST_Y);
        chk({tag, "_idle_busy"}, bus.oBusy, 0);
        chk({tag, "_idle_ready"}, bus.oReady, 1);
        chk({tag, "_idle_winvalid"}, bus.oWinValid, 0);
        feed_en = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.iPixel = '0;
        bus.iValid = 1'b0;
        bus.iSof   = 1'b0;
        bus.iHold  = 1'b0;
        #3;
        chk("rst_busy", bus.oBusy, 0);
        chk("rst_ready", bus.oReady, 1);
        chk("rst_clken", bus.oClken, 0);
        chk("rst_winvalid", bus.oWinValid, 0);
        chk("rst_cx", bus.oCx, 0);
        chk("rst_cy", bus.oCy, 0);
        chk("rst_border", bus.oBorder, 0);
        chk("rst_frame_done", bus.oFrameDone, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Start a frame, then reset in the middle of RUN.
        idx = 0;
        feed_en = 1;
        drive();
        repeat (6) step();
        chk("midrun_busy", bus.oBusy, 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", bus.oBusy, 0);
        chk("midrst_winvalid", bus.oWinValid, 0);
        feed_en = 0;
        drive();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_busy", bus.oBusy, 0);
        chk("post_rst_ready", bus.oReady, 1);
        chk("post_rst_winvalid", bus.oWinValid, 0);
        nosof_en = 1;
        drive();
        @(negedge clk);
        chk("nosof_clken", bus.oClken, 0);
        chk("nosof_ready", bus.oReady, 1);
        @(posedge clk);
        #1;
        chk("nosof_busy", bus.oBusy, 0);
        nosof_en = 0;
        drive();

        // Full frame, continuous valid, no hold.
        hold_en = 0;
        gap_en = 0;
        run_frame("f1");

        // Same frame with periodic hold and valid gaps.
        hold_en = 1;
        gap_en = 1;
        run_frame("f2");

        // Frame restarted by a second SOF at input pixel 44.
        hold_en = 0;
        gap_en = 0;
        restart_at = 44;
        run_frame("f3");
        chk("f3_pre_restart_win", pre_win, EXP_PRE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
